// File: rtl/instr_cache_dm.sv
// -----------------------------------------------------------------------------
// instr_cache_dm -- direct-mapped L1 instruction cache
//
// Sits between the IF stage and instruction memory. A hit returns the word in
// the same cycle; a miss stalls the core while the whole line is refilled from
// memory one word per accepted request; flush_i (fence.i) invalidates every
// line. The cache is read-only, so a conflicting line is simply overwritten.
//
// Parameters
//   LINES   number of cache lines (power of 2, >= 2)
//   WORDS   32-bit words per line (power of 2, >= 1)
//   ADDR_W  byte-address width of pc_i / mem_addr_o
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          synchronous reset, active-high
//   req_i          fetch request for pc_i this cycle
//   pc_i           fetch byte address, bits [1:0] ignored
//   flush_i        invalidate every line
//   instr_o        instruction word, zero unless instr_valid_o
//   instr_valid_o  hit: instr_o holds the word at pc_i
//   stall_o        cache busy or missing, IF must hold pc_i
//   mem_req_o      memory read request, held until mem_ack_i
//   mem_addr_o     word-aligned read address, stable while mem_req_o
//   mem_ack_i      one-cycle accept, mem_rdata_i valid in the same cycle
//   mem_rdata_i    read data
//
// Optional feature (macro ICACHE_PERF_EN)
//   Adds hit_cnt_o[31:0] (one count per hit cycle) and miss_cnt_o[31:0] (one
//   count per refill started). Both wrap at 2^32 and clear on rst_i.
// -----------------------------------------------------------------------------
module instr_cache_dm #(
    parameter int LINES  = 64,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic [31:0]       instr_o,
    output logic              instr_valid_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int LINE_W = ADDR_W - 2 - OFF_W;   // line address = idx + tag
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam int BEAT_W = (OFF_W > 0) ? OFF_W : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [LINE_W-1:0]  line_q, line_d;        // line being refilled
    logic               flush_pend_q, flush_pend_d;
    logic [LINES-1:0]   valid_q, valid_d;

    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES][WORDS];

    logic               data_we;
    logic               tag_we;
    logic               hit;
    logic               miss_start;

    // ---------------------------------------------------------------- address split
    logic [LINE_W-1:0]  pc_line;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic [BEAT_W-1:0]  pc_off;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic [ADDR_W-1:0]  fill_addr;
    logic               unused_pc_bits;

    assign pc_line        = pc_i[ADDR_W-1 -: LINE_W];
    assign pc_idx         = pc_line[IDX_W-1:0];
    assign pc_tag         = pc_line[LINE_W-1 -: TAG_W];
    assign fill_idx       = line_q[IDX_W-1:0];
    assign fill_tag       = line_q[LINE_W-1 -: TAG_W];
    assign unused_pc_bits = ^pc_i[1:0];

    // A single-word line has no offset field; the beat counter then stays a
    // 1-bit register that never selects anything but word 0.
    if (OFF_W > 0) begin : g_off
        assign pc_off    = pc_i[2 +: OFF_W];
        assign fill_addr = {line_q, beat_q, 2'b00};
    end else begin : g_no_off
        assign pc_off    = '0;
        assign fill_addr = {line_q, 2'b00};
    end

    // Hits are only served while idle and never in a flush cycle.
    assign hit = req_i && (state_q == IDLE) && !flush_i
              && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    assign miss_start = (state_q == IDLE) && (state_d == REFILL);

    // ---------------------------------------------------------------- FSM: state register
    // NOTE: every flop is written with <= so all always_ff blocks sample the
    // same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!flush_i && req_i && !hit) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack_i && (beat_q == LAST_BEAT)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        instr_valid_o = hit;
        instr_o       = hit ? data_q[pc_idx][pc_off] : 32'd0;
        stall_o       = (state_q == IDLE) ? (req_i && !hit) : 1'b1;
        mem_req_o     = (state_q == REFILL);
        mem_addr_o    = (state_q == REFILL) ? fill_addr : '0;
    end

    // ---------------------------------------------------------------- datapath next values
    always_comb begin
        beat_d       = beat_q;
        line_d       = line_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    valid_d = '0;
                end else if (req_i && !hit) begin
                    line_d = pc_line;
                    beat_d = '0;
                end
            end
            REFILL: begin
                // A flush cannot abort the burst: memory would be left with an
                // outstanding request. Remember it and drop the line at COMMIT.
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ack_i) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                end
            end
            COMMIT: begin
                flush_pend_d = 1'b0;
                if (flush_pend_q || flush_i) begin
                    valid_d = '0;
                end else begin
                    valid_d[fill_idx] = 1'b1;
                    tag_we            = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q       <= '0;
            line_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            beat_q       <= beat_d;
            line_q       <= line_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
        end
    end

    // NOTE: the data and tag arrays have no reset; valid_q alone decides
    // whether their contents can be observed, so stale values are harmless.
    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_q[fill_idx][beat_q] <= mem_rdata_i;
        end
        if (tag_we) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    // ---------------------------------------------------------------- performance counters
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q  + (hit        ? 32'd1 : 32'd0);
        miss_cnt_d = miss_cnt_q + (miss_start ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic unused_miss_start;
    assign unused_miss_start = miss_start;
`endif

endmodule

// File: tb/tb_instr_cache_dm.sv
// -----------------------------------------------------------------------------
// tb_instr_cache_dm -- self-checking bench for instr_cache_dm (LINES=4, WORDS=4)
//
// Memory returns word A as A ^ 32'hA5A5_0000 and acks two cycles after it
// sees a request. The reference model tracks which line address each cache
// slot holds; every fetch is predicted from that as either a same-cycle hit
// or a full-line refill followed by one commit cycle and then the hit.
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_instr_cache_dm;

    localparam int LINES  = 4;
    localparam int WORDS  = 4;
    localparam int ADDR_W = 32;
    localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_i;
    logic [ADDR_W-1:0] pc_i;
    logic              flush_i;
    logic [31:0]       instr_o;
    logic              instr_valid_o;
    logic              stall_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;
`ifdef ICACHE_PERF_EN
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    instr_cache_dm #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .stall_o       (stall_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
`endif
    );

    // ---------------------------------------------------------------- scoreboard
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    bit          model_valid [LINES];
    logic [31:0] model_line  [LINES];   // byte address / 16 of the resident line
    int          exp_hits;
    int          exp_misses;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / (4 * WORDS)) % LINES);
    endfunction

    function automatic bit resident(input logic [31:0] pc);
        return model_valid[slot_of(pc)] && (model_line[slot_of(pc)] == pc / (4 * WORDS));
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return (pc & ~32'h3) ^ MEM_XOR;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
    endtask

    // ---------------------------------------------------------------- memory
    initial begin
        int wait_cnt;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        wait_cnt    = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i || mem_ack_i || !mem_req_o) begin
                mem_ack_i = 1'b0;
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_addr_o ^ MEM_XOR;
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus tasks
    // All tasks start and end exactly on a falling edge.

    task automatic idle_cycle();
        req_i   = 1'b0;
        flush_i = 1'b0;
        #1;
        check("idle_stall", stall_o, 0);
        check("idle_valid", instr_valid_o, 0);
        check("idle_instr", instr_o, 0);
        check("idle_memreq", mem_req_o, 0);
        @(negedge clk_i);
    endtask

    // Fetch pc; flush_beat >= 0 pulses flush_i while that refill beat is pending.
    task automatic fetch(input logic [31:0] pc, input int flush_beat);
        int beats;
        int cycles;
        bit flushed;
        req_i   = 1'b1;
        pc_i    = pc;
        flush_i = 1'b0;
        #1;
        if (resident(pc)) begin
            check("hit_valid", instr_valid_o, 1);
            check("hit_instr", instr_o, word_at(pc));
            check("hit_stall", stall_o, 0);
            check("hit_memreq", mem_req_o, 0);
            exp_hits++;
            @(negedge clk_i);
            return;
        end
        check("miss_valid", instr_valid_o, 0);
        check("miss_instr", instr_o, 0);
        check("miss_stall", stall_o, 1);
        check("miss_memreq", mem_req_o, 0);
        exp_misses++;
        @(negedge clk_i);

        beats   = 0;
        cycles  = 0;
        flushed = 1'b0;
        while (beats < WORDS && cycles < 64) begin
            if (beats == flush_beat && !flushed) begin
                flush_i = 1'b1;
                flushed = 1'b1;
            end
            #1;
            check("refill_memreq", mem_req_o, 1);
            check("refill_stall", stall_o, 1);
            check("refill_valid", instr_valid_o, 0);
            if (mem_ack_i) begin
                check("refill_addr", mem_addr_o, (pc & ~32'hF) + 32'(4 * beats));
                beats++;
            end
            @(negedge clk_i);
            flush_i = 1'b0;
            cycles++;
        end
        check("refill_beats", beats, WORDS);

        #1;
        check("commit_stall", stall_o, 1);
        check("commit_memreq", mem_req_o, 0);
        check("commit_valid", instr_valid_o, 0);
        @(negedge clk_i);

        if (flushed) begin
            // Line was dropped; the next fetch of it must miss again.
            model_clear();
            return;
        end
        model_valid[slot_of(pc)] = 1'b1;
        model_line[slot_of(pc)]  = pc / (4 * WORDS);
        #1;
        check("fill_hit_valid", instr_valid_o, 1);
        check("fill_hit_instr", instr_o, word_at(pc));
        check("fill_hit_stall", stall_o, 0);
        exp_hits++;
        @(negedge clk_i);
    endtask

    task automatic flush_idle(input logic [31:0] pc);
        req_i   = 1'b1;
        pc_i    = pc;
        flush_i = 1'b1;
        #1;
        check("flush_idle_valid", instr_valid_o, 0);
        check("flush_idle_stall", stall_o, 1);
        check("flush_idle_memreq", mem_req_o, 0);
        @(negedge clk_i);
        flush_i = 1'b0;
        model_clear();
        req_i = 1'b0;
        #1;
        check("flush_no_refill", mem_req_o, 0);
        @(negedge clk_i);
    endtask

    // ---------------------------------------------------------------- main sequence
    initial begin
        rst_i      = 1'b1;
        req_i      = 1'b0;
        pc_i       = '0;
        flush_i    = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        model_clear();

        repeat (3) @(negedge clk_i);
        #1;
        check("rst_stall", stall_o, 0);
        check("rst_valid", instr_valid_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_memreq", mem_req_o, 0);
        check("rst_memaddr", mem_addr_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Cold miss then hits across the filled line.
        fetch(32'h00, -1);
        fetch(32'h04, -1);
        fetch(32'h08, -1);
        fetch(32'h0C, -1);
`ifdef ICACHE_PERF_EN
        #1;
        check("perf_miss_cold", miss_cnt_o, 1);
        check("perf_hit_cold", hit_cnt_o, 4);
        @(negedge clk_i);
`endif

        // Conflict on index 0 replaces the line.
        fetch(32'h40, -1);
        check("conflict_evicted", 32'(resident(32'h00)), 0);
        fetch(32'h00, -1);

        // Flush during beat 2 of a refill: burst completes, line not kept.
        fetch(32'h20, 2);
        fetch(32'h20, -1);

        // Reset in the middle of a refill.
        req_i = 1'b1;
        pc_i  = 32'h30;
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = 1'b0;
        #1;
        check("rst_mid_pre_memreq", mem_req_o, 1);
        @(negedge clk_i);
        #1;
        check("rst_mid_memreq", mem_req_o, 0);
        check("rst_mid_stall", stall_o, 0);
        check("rst_mid_memaddr", mem_addr_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
        fetch(32'h00, -1);

        // Randomised traffic over 8 tags x 4 slots, odd low pc bits included.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] pc;
            int          op;
            pc = ($urandom_range(0, 127) * 4) | $urandom_range(0, 3);
            op = $urandom_range(0, 9);
            if (op == 0)      idle_cycle();
            else if (op == 1) flush_idle(pc);
            else if (op == 2) fetch(pc, $urandom_range(0, WORDS - 1));
            else              fetch(pc, -1);
        end
        idle_cycle();

`ifdef ICACHE_PERF_EN
        #1;
        check("perf_miss_total", miss_cnt_o, 32'(exp_misses));
        check("perf_hit_total", hit_cnt_o, 32'(exp_hits));
        @(negedge clk_i);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
